// File: rtl/alu_pkg.sv
// Shared ALU encodings: op field, full 4-bit control codes, and the sequencer state enum.
package alu_pkg;

    localparam logic [1:0] ALU_OP_AND = 2'b00;
    localparam logic [1:0] ALU_OP_OR  = 2'b01;
    localparam logic [1:0] ALU_OP_ADD = 2'b10;
    localparam logic [1:0] ALU_OP_SLT = 2'b11;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/ALU_1bit.sv
// Combinational 1-bit MIPS ALU slice: optional operand inversion, AND/OR/ADD/less mux,
// plus the set (raw sum) and signed-overflow outputs used at the MSB position.
module ALU_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       Ainvert,
    input  logic       Binvert,
    input  logic       c_in,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       c_out,
    output logic       set,
    output logic       overflow
);

    logic aa;
    logic bb;
    logic sum;

    always_comb begin
        aa       = a ^ Ainvert;
        bb       = b ^ Binvert;
        sum      = aa ^ bb ^ c_in;
        c_out    = (aa & bb) | (aa & c_in) | (bb & c_in);
        set      = sum;
        overflow = c_in ^ c_out;
        result   = 1'b0;
        case (op)
            ALU_OP_AND: result = aa & bb;
            ALU_OP_OR:  result = aa | bb;
            ALU_OP_ADD: result = sum;
            ALU_OP_SLT: result = less;
            default:    result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer: runs one ALU_1bit slice LSB-first over WIDTH cycles with a
// registered carry, then publishes result/zero/overflow with a one-cycle valid.
module alu_bitserial_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned     IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             s_a, s_b, s_cin;
    logic             s_res, s_cout, s_set, s_ovf;
    logic [WIDTH-1:0] fin;

    always_comb begin
        s_a   = a_q[idx_q];
        s_b   = b_q[idx_q];
        s_cin = (idx_q == '0) ? ctrl_q[2] : carry_q;
    end

    ALU_1bit u_slice (
        .a        (s_a),
        .b        (s_b),
        .Ainvert  (ctrl_q[3]),
        .Binvert  (ctrl_q[2]),
        .c_in     (s_cin),
        .less     (1'b0),
        .op       (ctrl_q[1:0]),
        .result   (s_res),
        .c_out    (s_cout),
        .set      (s_set),
        .overflow (s_ovf)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        carry_d  = carry_q;
        work_d   = work_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        fin      = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    ctrl_d  = alu_ctrl;
                    carry_d = 1'b0;
                    work_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[idx_q] = s_res;
                carry_d       = s_cout;
                if (idx_q == IDX_LAST) begin
                    // MSB set/overflow are resolved straight from the slice on the
                    // last edge, so the final word lands together with DONE.
                    fin = work_d;
                    if (ctrl_q[1:0] == ALU_OP_SLT) begin
                        fin    = '0;
                        fin[0] = s_set ^ s_ovf;
                    end
                    state_d  = DONE;
                    result_d = fin;
                    zero_d   = ~|fin;
                    ovf_d    = s_ovf & (ctrl_q[1:0] == ALU_OP_ADD);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            carry_q  <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            carry_q  <= carry_d;
            work_q   <= work_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        ready    = (state_q != RUN);
        valid    = (state_q == DONE);
        result   = result_q;
        zero     = zero_q;
        overflow = ovf_q;
    end

endmodule
